// File: rtl/data_mem_resp.sv
// Data-memory responder: single outstanding load/store, optional wait states,
// byte/half/word access with extension on loads and lane masking on stores.
module data_mem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        stall
);

  // state | meaning
  // IDLE  | waiting for a request; latches it on the accepting edge
  // WAIT  | wait-state countdown on the latched request
  // RESP  | ready (and error) high for this single cycle

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;

  logic          lat_rd, lat_wr;
  logic [2:0]    lat_f3;
  logic [31:0]   lat_addr, lat_wdata;

  logic          req;
  logic          cur_rd, cur_wr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_addr, cur_wdata;
  logic          enter_resp;

  logic          f3_illegal, misaligned, out_of_range, acc_err;
  logic [31:0]   word, shifted, load_val, store_val;
  logic [3:0]    byte_en;
  logic [AW-1:0] idx;

  logic [31:0]   mem [DEPTH];

  assign req   = mem_read | mem_write;
  assign stall = req & ~ready;

  // In IDLE the access being decided is the one on the inputs (needed when
  // WAIT_CYCLES=0 and RESP is entered on the accepting edge); afterwards the
  // latched copy is used so input changes during WAIT are ignored.
  assign cur_rd    = (state == S_IDLE) ? mem_read  : lat_rd;
  assign cur_wr    = (state == S_IDLE) ? mem_write : lat_wr;
  assign cur_f3    = (state == S_IDLE) ? funct3    : lat_f3;
  assign cur_addr  = (state == S_IDLE) ? address   : lat_addr;
  assign cur_wdata = (state == S_IDLE) ? w_data    : lat_wdata;

  assign idx        = cur_addr[AW+1:2];
  assign enter_resp = (next_state == S_RESP) && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == '0) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Wait-state down-counter and request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      if (state == S_IDLE && req) begin
        cnt       <= CW'(CNT_INIT);
        lat_rd    <= mem_read;
        lat_wr    <= mem_write;
        lat_f3    <= funct3;
        lat_addr  <= address;
        lat_wdata <= w_data;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Access legality: size/alignment, funct3 set, range, read+write conflict
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    case (cur_f3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = cur_addr[0];
      3'b010: misaligned = (cur_addr[1:0] != 2'b00);
      3'b100: f3_illegal = cur_wr;
      3'b101: begin
        f3_illegal = cur_wr;
        misaligned = cur_addr[0];
      end
      default: f3_illegal = 1'b1;
    endcase
    out_of_range = (cur_addr[31:2] >= 30'(DEPTH));
    acc_err      = f3_illegal | misaligned | out_of_range | (cur_rd & cur_wr);
  end

  // Load extraction and store lane alignment
  always_comb begin
    word     = mem[idx];
    shifted  = word >> {cur_addr[1:0], 3'b000};
    load_val = word;
    case (cur_f3)
      3'b000: load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001: load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100: load_val = {24'd0, shifted[7:0]};
      3'b101: load_val = {16'd0, shifted[15:0]};
      default: load_val = word;
    endcase
    byte_en   = 4'b1111;
    store_val = cur_wdata;
    case (cur_f3)
      3'b000: begin
        byte_en   = 4'b0001 << cur_addr[1:0];
        store_val = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        store_val = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        store_val = cur_wdata;
      end
    endcase
  end

  // Store commit on the edge entering RESP; array itself is never reset
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wr && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_val[8*i +: 8];
      end
    end
  end

  // Registered response: ready/error pulse and load data
  always_ff @(posedge clk) begin
    if (reset) begin
      ready     <= 1'b0;
      error     <= 1'b0;
      read_data <= 32'd0;
    end else begin
      ready <= enter_resp;
      error <= enter_resp & acc_err;
      if (enter_resp && cur_rd) read_data <= acc_err ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a WAIT_CYCLES=2 instance exercising
// stores/loads/errors/reset abort, and a WAIT_CYCLES=0 instance for
// back-to-back timing.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        reset;

  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, w_data;
  logic [31:0] read_data;
  logic        ready, error, stall;

  logic        b_read, b_write;
  logic [2:0]  b_f3;
  logic [31:0] b_addr, b_wdata;
  logic [31:0] b_rdata;
  logic        b_ready, b_error, b_stall;

  int checks = 0;
  int errors = 0;

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .address(address), .w_data(w_data),
    .read_data(read_data), .ready(ready), .error(error), .stall(stall)
  );

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset),
    .mem_read(b_read), .mem_write(b_write), .funct3(b_f3),
    .address(b_addr), .w_data(b_wdata),
    .read_data(b_rdata), .ready(b_ready), .error(b_error), .stall(b_stall)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One access on u0, starting just after a negedge; expects ready in cycle 3.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err,
                        input logic chk_data, input logic [31:0] exp_data);
    int cyc;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    address   = a;
    w_data    = wd;
    #1;
    chk(tag, "stall_req", stall, 1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cyc++;
      if (ready) break;
      chk(tag, "stall_wait", stall, 1);
    end
    chk(tag, "latency", cyc, 3);
    chk(tag, "error", error, exp_err);
    if (chk_data) chk(tag, "data", read_data, exp_data);
    chk(tag, "stall_ready", stall, 0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk(tag, "ready_pulse", ready, 0);
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 0; mem_write = 0; funct3 = 0; address = 0; w_data = 0;
    b_read = 0; b_write = 0; b_f3 = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset", "ready", ready, 0);
    chk("reset", "error", error, 0);
    chk("reset", "rdata", read_data, 0);
    chk("reset", "stall", stall, 0);
    chk("reset", "b_ready", b_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    access("sw10",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    access("lw10a", 1, 0, 3'b010, 32'h10, 0, 0, 1, 32'hDEADBEEF);
    access("sb11",  0, 1, 3'b000, 32'h11, 32'h000000AA, 0, 0, 0);
    access("lb11",  1, 0, 3'b000, 32'h11, 0, 0, 1, 32'hFFFFFFAA);
    access("lbu11", 1, 0, 3'b100, 32'h11, 0, 0, 1, 32'h000000AA);
    access("lw10b", 1, 0, 3'b010, 32'h10, 0, 0, 1, 32'hDEADAAEF);
    access("sh12",  0, 1, 3'b001, 32'h12, 32'h00008001, 0, 0, 0);
    // store must leave read_data from the previous load untouched
    chk("sh12", "rdata_kept", read_data, 32'hDEADAAEF);
    access("lh12",  1, 0, 3'b001, 32'h12, 0, 0, 1, 32'hFFFF8001);
    access("lhu12", 1, 0, 3'b101, 32'h12, 0, 0, 1, 32'h00008001);
    access("lw10c", 1, 0, 3'b010, 32'h10, 0, 0, 1, 32'h8001AAEF);
    access("lb13",  1, 0, 3'b000, 32'h13, 0, 0, 1, 32'hFFFFFF80);

    access("lw13",   1, 0, 3'b010, 32'h13,   0, 1, 1, 32'h0);
    access("sh11",   0, 1, 3'b001, 32'h11,   32'hFFFF, 1, 0, 0);
    access("lw1000", 1, 0, 3'b010, 32'h1000, 0, 1, 1, 32'h0);
    access("f3_011", 1, 0, 3'b011, 32'h10,   0, 1, 1, 32'h0);
    access("sbu",    0, 1, 3'b100, 32'h10,   32'h55, 1, 0, 0);
    access("rdwr",   1, 1, 3'b010, 32'h10,   32'h0, 1, 0, 0);
    access("lw10d",  1, 0, 3'b010, 32'h10,   0, 0, 1, 32'h8001AAEF);

    // Reset mid-access aborts the store
    access("sw20",  0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 0);
    access("lw20a", 1, 0, 3'b010, 32'h20, 0, 0, 1, 32'hCAFEF00D);
    mem_write = 1'b1; funct3 = 3'b010; address = 32'h20; w_data = 32'h12345678;
    @(negedge clk);
    reset = 1'b1;
    mem_write = 1'b0;
    @(negedge clk);
    chk("rst_abort", "ready", ready, 0);
    chk("rst_abort", "error", error, 0);
    chk("rst_abort", "rdata", read_data, 0);
    reset = 1'b0;
    @(negedge clk);
    access("lw20b", 1, 0, 3'b010, 32'h20, 0, 0, 1, 32'hCAFEF00D);

    // Zero wait states: latency 1, back-to-back ready every second cycle
    b_write = 1'b1; b_f3 = 3'b010; b_addr = 32'h0; b_wdata = 32'h11223344;
    #1;
    chk("z_sw", "stall_req", b_stall, 1);
    @(negedge clk);
    chk("z_sw", "ready", b_ready, 1);
    chk("z_sw", "stall", b_stall, 0);
    b_write = 1'b0;
    @(negedge clk);
    b_read = 1'b1;
    #1;
    chk("z_lw", "stall_req", b_stall, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("z_lw", "ready", b_ready, (k % 2 == 1) ? 1 : 0);
      chk("z_lw", "stall", b_stall, (k % 2 == 1) ? 0 : 1);
      if (k % 2 == 1) chk("z_lw", "data", b_rdata, 32'h11223344);
    end
    b_read = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
